// File: rtl/idex_stage_reg_if.sv
// -----------------------------------------------------------------------------
// Shared types and the ID/EX pipeline interface.
//
// cpu_types_pkg          : datapath widths (words, register indices, immediates)
// control_unit_types_pkg : control-field encodings plus the packed ID/EX bundle
// idexpipe_if            : one bundle of decode fields plus the en/flush controls
//   modport id : stage-register view of the decode side (everything is input)
//   modport ex : stage-register view of the execute side (bundle fields output)
// -----------------------------------------------------------------------------

package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef logic [4:0]  shamt_t;
  typedef logic [15:0] imm_t;
  typedef logic [5:0]  opfunc_t;
endpackage

package control_unit_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } regdst_t;

  typedef enum logic [1:0] {
    MR_ALU = 2'd0,
    MR_MEM = 2'd1,
    MR_NPC = 2'd2,
    MR_LUI = 2'd3
  } memtoreg_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } extop_t;

  // Everything that crosses the ID/EX boundary, in one packed record.
  typedef struct packed {
    opfunc_t   opfunc;
    regdst_t   RegDst;
    memtoreg_t MemtoReg;
    logic      ALUSrc;
    logic      RegWEN;
    logic      dWENi;
    logic      dRENi;
    aluop_t    ALUOp;
    extop_t    ExtOp;
    logic      halt;
    regbits_t  rs;
    regbits_t  rt;
    regbits_t  rd;
    shamt_t    shamt;
    imm_t      imm;
    word_t     busA;
    word_t     busB;
    word_t     npc;
  } idex_bundle_t;
endpackage

interface idexpipe_if;
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;

  opfunc_t   opfunc;
  regdst_t   RegDst;
  memtoreg_t MemtoReg;
  logic      ALUSrc;
  logic      RegWEN;
  logic      dWENi;
  logic      dRENi;
  aluop_t    ALUOp;
  extop_t    ExtOp;
  logic      halt;
  regbits_t  rs;
  regbits_t  rt;
  regbits_t  rd;
  shamt_t    shamt;
  imm_t      imm;
  word_t     busA;
  word_t     busB;
  word_t     npc;
  logic      en;
  logic      flush;

  modport id (
    input opfunc, RegDst, MemtoReg, ALUSrc, RegWEN, dWENi, dRENi, ALUOp,
          ExtOp, halt, rs, rt, rd, shamt, imm, busA, busB, npc, en, flush
  );

  modport ex (
    output opfunc, RegDst, MemtoReg, ALUSrc, RegWEN, dWENi, dRENi, ALUOp,
           ExtOp, halt, rs, rt, rd, shamt, imm, busA, busB, npc
  );
endinterface

// File: rtl/idex_stage_reg.sv
// -----------------------------------------------------------------------------
// idex_stage_reg : decode-to-execute pipeline register of the 5-stage MIPS core.
//
// Ports
//   CLK         in   core clock, rising edge
//   nRST        in   asynchronous active-low reset (loads a bubble)
//   idif        in   idexpipe_if.id : decode bundle plus en (advance) / flush
//   exif        out  idexpipe_if.ex : registered copy of the decode bundle
//   valid       out  exif holds a real instruction (0 = bubble)
//   luhaz_stall out  combinational load-use stall request to PC and IF/ID
//
// Edge priority: flush > halt freeze > hold (en=0) > load-use bubble > load.
//
// Build option IDEX_LOADUSE_STALL_EN
//   defined   : load-use comparator and automatic one-bubble insertion
//   undefined : luhaz_stall tied low, load-use resolved elsewhere
// -----------------------------------------------------------------------------

module idex_stage_reg
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  idexpipe_if.id idif,
  idexpipe_if.ex exif,
  output logic   valid,
  output logic   luhaz_stall
);

  // A bubble is an all-zero instruction: no write-back, no memory access.
  function automatic idex_bundle_t bubble_bundle();
    idex_bundle_t b;
    b.opfunc   = 6'd0;
    b.RegDst   = RD_RT;
    b.MemtoReg = MR_ALU;
    b.ALUSrc   = 1'b0;
    b.RegWEN   = 1'b0;
    b.dWENi    = 1'b0;
    b.dRENi    = 1'b0;
    b.ALUOp    = ALU_SLL;
    b.ExtOp    = EXT_ZERO;
    b.halt     = 1'b0;
    b.rs       = 5'd0;
    b.rt       = 5'd0;
    b.rd       = 5'd0;
    b.shamt    = 5'd0;
    b.imm      = 16'd0;
    b.busA     = 32'd0;
    b.busB     = 32'd0;
    b.npc      = 32'd0;
    return b;
  endfunction

  idex_bundle_t r_bundle;
  logic         r_valid;
  idex_bundle_t w_id_bundle;
  idex_bundle_t w_next_bundle;
  logic         w_next_valid;
  logic         w_frozen;
  logic         w_luhaz;

  // Gather the decode-side fields into one record.
  assign w_id_bundle.opfunc   = idif.opfunc;
  assign w_id_bundle.RegDst   = idif.RegDst;
  assign w_id_bundle.MemtoReg = idif.MemtoReg;
  assign w_id_bundle.ALUSrc   = idif.ALUSrc;
  assign w_id_bundle.RegWEN   = idif.RegWEN;
  assign w_id_bundle.dWENi    = idif.dWENi;
  assign w_id_bundle.dRENi    = idif.dRENi;
  assign w_id_bundle.ALUOp    = idif.ALUOp;
  assign w_id_bundle.ExtOp    = idif.ExtOp;
  assign w_id_bundle.halt     = idif.halt;
  assign w_id_bundle.rs       = idif.rs;
  assign w_id_bundle.rt       = idif.rt;
  assign w_id_bundle.rd       = idif.rd;
  assign w_id_bundle.shamt    = idif.shamt;
  assign w_id_bundle.imm      = idif.imm;
  assign w_id_bundle.busA     = idif.busA;
  assign w_id_bundle.busB     = idif.busB;
  assign w_id_bundle.npc      = idif.npc;

  // A valid halt sitting in EX freezes the register until flushed or reset.
  assign w_frozen = r_valid & r_bundle.halt;

`ifdef IDEX_LOADUSE_STALL_EN
  logic w_ex_is_load;
  logic w_rs_match;
  logic w_rt_match;
  logic w_rt_read;

  // Only a real load with a non-zero destination can create a hazard.
  assign w_ex_is_load = r_valid & r_bundle.dRENi & (r_bundle.rt != 5'd0);
  assign w_rs_match   = (r_bundle.rt == idif.rs);
  assign w_rt_match   = (r_bundle.rt == idif.rt);
  // rt is a source for R-type ops (ALUSrc=0) and for stores (store data).
  assign w_rt_read    = ~idif.ALUSrc | idif.dWENi;
  assign w_luhaz      = w_ex_is_load & (w_rs_match | (w_rt_match & w_rt_read));
`else
  assign w_luhaz = 1'b0;
`endif

  assign luhaz_stall = w_luhaz;

  // Next-state selection in edge priority order.
  always_comb begin
    w_next_bundle = r_bundle;
    w_next_valid  = r_valid;
    if (idif.flush) begin
      w_next_bundle = bubble_bundle();
      w_next_valid  = 1'b0;
    end else if (w_frozen) begin
      w_next_bundle = r_bundle;
      w_next_valid  = r_valid;
    end else if (!idif.en) begin
      w_next_bundle = r_bundle;
      w_next_valid  = r_valid;
`ifdef IDEX_LOADUSE_STALL_EN
    end else if (w_luhaz) begin
      // The bubble has dRENi=0, so this fires at most once per load.
      w_next_bundle = bubble_bundle();
      w_next_valid  = 1'b0;
`endif
    end else begin
      w_next_bundle = w_id_bundle;
      w_next_valid  = 1'b1;
    end
  end

  // Stage register with asynchronous reset to a bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_bundle <= bubble_bundle();
      r_valid  <= 1'b0;
    end else begin
      r_bundle <= w_next_bundle;
      r_valid  <= w_next_valid;
    end
  end

  // Execute side is driven straight from the register.
  assign exif.opfunc   = r_bundle.opfunc;
  assign exif.RegDst   = r_bundle.RegDst;
  assign exif.MemtoReg = r_bundle.MemtoReg;
  assign exif.ALUSrc   = r_bundle.ALUSrc;
  assign exif.RegWEN   = r_bundle.RegWEN;
  assign exif.dWENi    = r_bundle.dWENi;
  assign exif.dRENi    = r_bundle.dRENi;
  assign exif.ALUOp    = r_bundle.ALUOp;
  assign exif.ExtOp    = r_bundle.ExtOp;
  assign exif.halt     = r_bundle.halt;
  assign exif.rs       = r_bundle.rs;
  assign exif.rt       = r_bundle.rt;
  assign exif.rd       = r_bundle.rd;
  assign exif.shamt    = r_bundle.shamt;
  assign exif.imm      = r_bundle.imm;
  assign exif.busA     = r_bundle.busA;
  assign exif.busB     = r_bundle.busB;
  assign exif.npc      = r_bundle.npc;
  assign valid         = r_valid;

endmodule

// File: tb/tb_idex_stage_reg.sv
// -----------------------------------------------------------------------------
// Testbench for idex_stage_reg: a reference model of the stage register's
// behaviour checked against the DUT every negative clock edge, plus directed
// scenarios with literal expectations.
// -----------------------------------------------------------------------------

module tb_idex_stage_reg;
  import control_unit_types_pkg::*;

`ifdef IDEX_LOADUSE_STALL_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  opfunc;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    logic        alusrc;
    logic        regwen;
    logic        dwen;
    logic        dren;
    logic [3:0]  aluop;
    logic        extop;
    logic        halt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] npc;
  } instr_t;

  logic   CLK;
  logic   nRST;
  logic   valid;
  logic   luhaz_stall;
  instr_t drv;
  logic   drv_en;
  logic   drv_flush;
  instr_t got;
  instr_t m_ex;
  logic   m_valid;
  int     n_tests;
  int     n_fail;

  idexpipe_if idb ();
  idexpipe_if exb ();

  assign idb.opfunc   = drv.opfunc;
  assign idb.RegDst   = regdst_t'(drv.regdst);
  assign idb.MemtoReg = memtoreg_t'(drv.memtoreg);
  assign idb.ALUSrc   = drv.alusrc;
  assign idb.RegWEN   = drv.regwen;
  assign idb.dWENi    = drv.dwen;
  assign idb.dRENi    = drv.dren;
  assign idb.ALUOp    = aluop_t'(drv.aluop);
  assign idb.ExtOp    = extop_t'(drv.extop);
  assign idb.halt     = drv.halt;
  assign idb.rs       = drv.rs;
  assign idb.rt       = drv.rt;
  assign idb.rd       = drv.rd;
  assign idb.shamt    = drv.shamt;
  assign idb.imm      = drv.imm;
  assign idb.busA     = drv.busa;
  assign idb.busB     = drv.busb;
  assign idb.npc      = drv.npc;
  assign idb.en       = drv_en;
  assign idb.flush    = drv_flush;
  assign exb.en       = 1'b0;
  assign exb.flush    = 1'b0;

  idex_stage_reg dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .idif        (idb),
    .exif        (exb),
    .valid       (valid),
    .luhaz_stall (luhaz_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    got.opfunc   = exb.opfunc;
    got.regdst   = exb.RegDst;
    got.memtoreg = exb.MemtoReg;
    got.alusrc   = exb.ALUSrc;
    got.regwen   = exb.RegWEN;
    got.dwen     = exb.dWENi;
    got.dren     = exb.dRENi;
    got.aluop    = exb.ALUOp;
    got.extop    = exb.ExtOp;
    got.halt     = exb.halt;
    got.rs       = exb.rs;
    got.rt       = exb.rt;
    got.rd       = exb.rd;
    got.shamt    = exb.shamt;
    got.imm      = exb.imm;
    got.busa     = exb.busA;
    got.busb     = exb.busB;
    got.npc      = exb.npc;
  end

  // Does the instruction now in decode need the value a load in EX has not yet fetched?
  function automatic bit model_hazard(input instr_t ex, input bit ex_valid, input instr_t id);
    bit reads_rt;
    if (!HAZ_EN || !ex_valid || !ex.dren || ex.rt == 5'd0) return 1'b0;
    reads_rt = (id.alusrc == 1'b0) || (id.dwen == 1'b1);
    return (id.rs == ex.rt) || (reads_rt && id.rt == ex.rt);
  endfunction

  // Reference model: what EX must hold after each edge.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_ex    <= '0;
      m_valid <= 1'b0;
    end else if (drv_flush) begin
      m_ex    <= '0;
      m_valid <= 1'b0;
    end else if (m_valid && m_ex.halt) begin
      m_ex    <= m_ex;
    end else if (!drv_en) begin
      m_ex    <= m_ex;
    end else if (model_hazard(m_ex, m_valid, drv)) begin
      m_ex    <= '0;
      m_valid <= 1'b0;
    end else begin
      m_ex    <= drv;
      m_valid <= 1'b1;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    n_tests++;
    if (got !== m_ex) begin
      n_fail++;
      $display("FAIL model_exif t=%0t: got %h expected %h", $time, got, m_ex);
    end
    n_tests++;
    if (valid !== m_valid) begin
      n_fail++;
      $display("FAIL model_valid t=%0t: got %b expected %b", $time, valid, m_valid);
    end
    n_tests++;
    if (luhaz_stall !== model_hazard(m_ex, m_valid, drv)) begin
      n_fail++;
      $display("FAIL model_luhaz t=%0t: got %b expected %b", $time, luhaz_stall,
               model_hazard(m_ex, m_valid, drv));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_lw(input logic [4:0] rt);
    drv        = '0;
    drv.dren   = 1'b1;
    drv.regwen = 1'b1;
    drv.alusrc = 1'b1;
    drv.memtoreg = 2'd1;
    drv.aluop  = 4'd2;
    drv.rs     = 5'd29;
    drv.rt     = rt;
    drv.imm    = 16'h0010;
    drv.npc    = 32'h0000_0100;
  endtask

  // Load-use vectors: {id.rs, id.rt, id.alusrc, id.dwen, ex.rt, hazard}
  logic [17:0] haz_vec [5];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    nRST      = 1'b0;
    drv       = '0;
    drv_en    = 1'b0;
    drv_flush = 1'b0;

    // Reset state
    #12;
    check("reset_valid", {63'd0, valid}, 64'd0);
    check("reset_regwen", {63'd0, exb.RegWEN}, 64'd0);
    check("reset_luhaz", {63'd0, luhaz_stall}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Normal load
    drv_en    = 1'b1;
    drv.busa  = 32'h0000_1234;
    drv.rs    = 5'd5;
    drv.regwen = 1'b1;
    step(1);
    check("load_busA", {32'd0, exb.busA}, 64'h1234);
    check("load_rs", {59'd0, exb.rs}, 64'd5);
    check("load_regwen", {63'd0, exb.RegWEN}, 64'd1);
    check("load_valid", {63'd0, valid}, 64'd1);

    // Hold
    drv.npc = 32'h40;
    step(1);
    check("hold_npc_loaded", {32'd0, exb.npc}, 64'h40);
    drv_en  = 1'b0;
    drv.npc = 32'h44;
    step(3);
    check("hold_npc_kept", {32'd0, exb.npc}, 64'h40);
    drv_en = 1'b1;
    step(1);
    check("hold_release_npc", {32'd0, exb.npc}, 64'h44);

    // Asynchronous reset between edges
    #1;
    nRST = 1'b0;
    #1;
    check("midreset_regwen", {63'd0, exb.RegWEN}, 64'd0);
    check("midreset_busA", {32'd0, exb.busA}, 64'd0);
    check("midreset_valid", {63'd0, valid}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step(1);
    check("after_reset_busA", {32'd0, exb.busA}, 64'h1234);

    // Halt freeze
    drv.halt = 1'b1;
    drv.busa = 32'h0000_AAAA;
    step(1);
    check("halt_loaded", {63'd0, exb.halt}, 64'd1);
    drv.halt = 1'b0;
    drv.busa = 32'h0000_BBBB;
    drv.rs   = 5'd7;
    step(4);
    check("freeze_busA", {32'd0, exb.busA}, 64'hAAAA);
    check("freeze_halt", {63'd0, exb.halt}, 64'd1);
    check("freeze_valid", {63'd0, valid}, 64'd1);

    // Flush beats en=0 and the freeze
    drv_en    = 1'b0;
    drv_flush = 1'b1;
    step(1);
    check("flush_halt", {63'd0, exb.halt}, 64'd0);
    check("flush_valid", {63'd0, valid}, 64'd0);
    check("flush_busA", {32'd0, exb.busA}, 64'd0);
    drv_flush = 1'b0;
    drv_en    = 1'b1;
    step(1);
    check("unfrozen_busA", {32'd0, exb.busA}, 64'hBBBB);

    // Load-use: lw rt=8 then add rs=8
    set_lw(5'd8);
    step(1);
    drv = '0;
    drv.rs = 5'd8; drv.rt = 5'd9; drv.rd = 5'd10;
    drv.regwen = 1'b1; drv.regdst = 2'd1; drv.aluop = 4'd2;
    #1;
    check("luhaz_add", {63'd0, luhaz_stall}, {63'd0, HAZ_EN});
    drv_en = 1'b0;
    step(2);
    check("luhaz_held_en0", {63'd0, luhaz_stall}, {63'd0, HAZ_EN});
    check("luhaz_held_rt", {59'd0, exb.rt}, 64'd8);
    drv_en = 1'b1;
    step(1);
    check("luhaz_bubble_valid", {63'd0, valid}, {63'd0, ~HAZ_EN});
    if (HAZ_EN) begin
      check("luhaz_cleared", {63'd0, luhaz_stall}, 64'd0);
      step(1);
    end
    check("add_loaded_rs", {59'd0, exb.rs}, 64'd8);
    check("add_loaded_valid", {63'd0, valid}, 64'd1);

    // Same stimulus with register 0 never stalls
    set_lw(5'd0);
    step(1);
    drv = '0;
    drv.regwen = 1'b1; drv.aluop = 4'd2;
    #1;
    check("luhaz_r0", {63'd0, luhaz_stall}, 64'd0);

    // Hazard and flush on the same edge
    set_lw(5'd12);
    step(1);
    drv = '0;
    drv.rs = 5'd12; drv.regwen = 1'b1;
    drv_flush = 1'b1;
    #1;
    check("luhaz_with_flush", {63'd0, luhaz_stall}, {63'd0, HAZ_EN});
    step(1);
    check("luhaz_flush_valid", {63'd0, valid}, 64'd0);
    drv_flush = 1'b0;

    // Operand-usage table
    haz_vec[0] = {5'd8, 5'd9, 1'b0, 1'b0, 5'd8, 1'b1};
    haz_vec[1] = {5'd3, 5'd8, 1'b0, 1'b0, 5'd8, 1'b1};
    haz_vec[2] = {5'd3, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0};
    haz_vec[3] = {5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1};
    haz_vec[4] = {5'd4, 5'd6, 1'b0, 1'b0, 5'd8, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drv_flush = 1'b1;
      step(1);
      drv_flush = 1'b0;
      set_lw(haz_vec[i][5:1]);
      step(1);
      drv = '0;
      drv.rs     = haz_vec[i][17:13];
      drv.rt     = haz_vec[i][12:8];
      drv.alusrc = haz_vec[i][7];
      drv.dwen   = haz_vec[i][6];
      drv.busb   = 32'h5000 + i;
      #1;
      check($sformatf("luhaz_table_%0d", i), {63'd0, luhaz_stall},
            {63'd0, haz_vec[i][0] & HAZ_EN});
      step(2);
    end

    step(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
